// File: rtl/down_counter32_bank.sv
// ---------------------------------------------------------------------------
// down_counter32_bank
//
// Bank of N_INST independent 32-bit down-counters that share one load port,
// one command port (start/stop) and one read port. Each instance is IDLE,
// RUN or EXPIRED. A running instance decrements once per clock0 edge and
// stops at zero with its expiry flag set. The flag stays set until the
// instance is loaded again.
//
// Optional build macro:
//   DOWN_COUNTER_AUTO_RELOAD_EN - when defined, an instance that reaches the
//   end of its count reloads from its reload register and keeps running,
//   provided that register is non-zero. Its expiry flag then pulses for one
//   cycle per period. When the macro is undefined, no reload datapath is
//   built.
//
// Parameters:
//   N_INST      number of counter instances (2..128)
//   IDW         width of every id port
//
// Ports:
//   clock0      in   1       the only clock
//   reset       in   1       asynchronous, active-high reset
//   load        in   1       loads load_value into instance load_id
//   load_id     in   IDW     target instance of load
//   load_value  in   32      start / reload value
//   start       in   1       arms instance cmd_id
//   stop        in   1       halts instance cmd_id (wins over start)
//   cmd_id      in   IDW     target instance of start / stop
//   rd_id       in   IDW     read-select instance
//   count       out  32      count of instance rd_id (0 when out of range)
//   expired     out  N_INST  per-instance expiry flags, registered
//   expired_any out  1       OR of expired
// ---------------------------------------------------------------------------
module down_counter32_bank #(
  parameter int N_INST = 8,
  parameter int IDW    = $clog2(N_INST)
) (
  input  logic              clock0,
  input  logic              reset,
  input  logic              load,
  input  logic [IDW-1:0]    load_id,
  input  logic [31:0]       load_value,
  input  logic              start,
  input  logic              stop,
  input  logic [IDW-1:0]    cmd_id,
  input  logic [IDW-1:0]    rd_id,
  output logic [31:0]       count,
  output logic [N_INST-1:0] expired,
  output logic              expired_any
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  // Decrement that can never wrap below zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  logic [31:0] w_cnt [N_INST];

  for (genvar g = 0; g < N_INST; g++) begin : g_inst
    localparam logic [IDW-1:0] ID = IDW'(g);

    logic [31:0] r_count;
    logic [1:0]  r_state;
    logic        r_expired;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [31:0] r_reload;
`endif

    logic w_ld;
    logic w_st;
    logic w_sp;

    // Ids at or above N_INST match no instance, so such commands fall away.
    // Start is masked by stop so that stop wins when both arrive together.
    assign w_ld = load  && (load_id == ID);
    assign w_sp = stop  && (cmd_id  == ID);
    assign w_st = start && !stop && (cmd_id == ID);

    always_ff @(posedge clock0 or posedge reset) begin
      if (reset) begin
        r_count   <= 32'd0;
        r_state   <= ST_IDLE;
        r_expired <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        r_reload  <= 32'd0;
`endif
      end else if (w_ld) begin
        // Load takes effect first; a same-cycle start is then judged on the
        // freshly loaded value, and a same-cycle stop has nothing to halt.
        r_count <= load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        r_reload <= load_value;
`endif
        if (w_st && (load_value == 32'd0)) begin
          r_state   <= ST_EXPIRED;
          r_expired <= 1'b1;
        end else if (w_st) begin
          r_state   <= ST_RUN;
          r_expired <= 1'b0;
        end else begin
          r_state   <= ST_IDLE;
          r_expired <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Count is left as-is on the arming edge; decrementing starts
            // on the following edge.
            if (w_st && (r_count == 32'd0)) begin
              r_state   <= ST_EXPIRED;
              r_expired <= 1'b1;
            end else if (w_st) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_sp) begin
              r_state   <= ST_IDLE;
              r_expired <= 1'b0;
            end else if (r_count <= 32'd1) begin
              // Terminal edge. "<= 1" also catches a zero count, so the
              // counter can never wrap even from an unexpected state.
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              if (r_reload != 32'd0) begin
                r_count   <= r_reload;
                r_expired <= 1'b1;
              end else begin
                r_count   <= 32'd0;
                r_state   <= ST_EXPIRED;
                r_expired <= 1'b1;
              end
`else
              r_count   <= 32'd0;
              r_state   <= ST_EXPIRED;
              r_expired <= 1'b1;
`endif
            end else begin
              // Clearing here ends a one-cycle reload pulse. In the
              // non-reloading build the flag is already low in RUN.
              r_count   <= sat_dec(r_count);
              r_expired <= 1'b0;
            end
          end
          ST_EXPIRED: begin
            // Sticky until the next load; start and stop are ignored.
          end
          default: begin
            r_state   <= ST_IDLE;
            r_expired <= 1'b0;
          end
        endcase
      end
    end

    assign w_cnt[g]   = r_count;
    assign expired[g] = r_expired;
  end

  // Combinational read port. An rd_id with no matching instance reads 0.
  always_comb begin
    count = 32'd0;
    for (int i = 0; i < N_INST; i++) begin
      if (rd_id == IDW'(i)) begin
        count = w_cnt[i];
      end
    end
  end

  assign expired_any = |expired;

endmodule

// File: doc/down_counter32_bank.md
DOWN_COUNTER32_BANK -- requirements
Module: down_counter32_bank

Interface
REQ-001 SHALL have parameter N_INST, default 8, meaning the number of independent down-counter instances (2..128).
REQ-002 SHALL have parameter IDW, default $clog2(N_INST), meaning the width of every id port.
REQ-003 SHALL have port clock0  input  1  the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  a write strobe that loads load_value into instance load_id.
REQ-006 SHALL have port load_id  input  IDW  the target instance of load.
REQ-007 SHALL have port load_value  input  32  the start and reload value.
REQ-008 SHALL have port start  input  1  an arm strobe for instance cmd_id.
REQ-009 SHALL have port stop  input  1  a halt strobe for instance cmd_id.
REQ-010 SHALL have port cmd_id  input  IDW  the target instance of start and stop.
REQ-011 SHALL have port rd_id  input  IDW  the read-select instance.
REQ-012 SHALL have port count  output  32  the current count of instance rd_id, combinational read.
REQ-013 SHALL have port expired  output  N_INST  the per-instance expiry flags, registered.
REQ-014 SHALL have port expired_any  output  1  the OR of expired, combinational.

Function
REQ-015 SHALL give each instance a 32-bit count, a 32-bit reload register, and a state in {IDLE, RUN, EXPIRED}.
REQ-016 SHALL, on load (IDLE/RUN/EXPIRED): count <= load_value, reload <= load_value, state <= IDLE, expired bit <= 0.
REQ-017 SHALL, on start in IDLE: state <= RUN if count > 0; state <= EXPIRED with expired bit set if count == 0; count unchanged at that edge.
REQ-018 SHALL decrement count by 1 on each clock0 edge in RUN, with the first decrement on the edge after the start edge.
REQ-019 SHALL, on RUN with count == 1 at the edge: count <= 0, state <= EXPIRED, expired bit <= 1.
REQ-020 SHALL treat start in RUN or EXPIRED as ignored.
REQ-021 SHALL, on stop in RUN: state <= IDLE with count held; stop in IDLE/EXPIRED is ignored.
REQ-022 SHALL, when load and start/stop target the same id in one cycle, apply load first and then start (evaluated on load_value); stop is then a no-op.
REQ-023 SHALL give stop priority when start and stop are asserted together.
REQ-024 SHALL ignore any command whose id >= N_INST, and SHALL return count = 0 for rd_id >= N_INST.
REQ-025 SHALL never let count underflow below 0 or wrap.
REQ-026 SHALL hold instances not addressed by a command unaffected by it.

Reset
REQ-027 SHALL, while reset is high, force every count = 0, reload = 0, state = IDLE, expired = 0, expired_any = 0, independent of clock0.
REQ-028 SHALL abort any run in progress when reset is asserted mid-run, with no residual expiry.

Configuration
REQ-029 SHALL provide macro DOWN_COUNTER_AUTO_RELOAD_EN.
REQ-030 SHALL, with DOWN_COUNTER_AUTO_RELOAD_EN defined, on RUN with count == 1 and reload > 0: count <= reload, stay in RUN, and pulse the expired bit high for exactly one cycle.
REQ-031 SHALL, with DOWN_COUNTER_AUTO_RELOAD_EN defined and reload == 0, behave per REQ-019.
REQ-032 SHALL, without DOWN_COUNTER_AUTO_RELOAD_EN, make expired sticky until load per REQ-016/REQ-019, and SHALL not synthesize the reload path beyond the register.

Verification (N_INST=8)
REQ-033 SHALL cover basic expiry: load id3=5, start id3 at cycle T -> count reads 5,4,3,2,1,0 at T+1..T+6; expired[3]=1 from T+6; all other flags stay 0.
REQ-034 SHALL cover stop/resume: load id0=10, start, stop after 4 decrements -> count holds 6; start again -> reaches 0 six cycles later.
REQ-035 SHALL cover simultaneous events: load id2=0 with start id2 in the same cycle -> expired[2]=1 on the next edge; start+stop on id1 -> stays IDLE.
REQ-036 SHALL cover reset mid-run: id5 running at count 100, assert reset asynchronously between edges -> count=0 and expired=0 immediately; no decrement after release.
REQ-037 SHALL cover auto-reload (macro defined): load id7=3, start -> expired[7] pulses every 3 cycles and count cycles 3,2,1,3,2,1.
REQ-038 SHALL cover out-of-range ids: with N_INST=6, load id 7 leaves all state unchanged and rd_id 7 reads 0.
